// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: register-index width,
// the x0 register index and the sequencer state encoding.
package pipe_hazard_ctrl_pkg;

   localparam int REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

   typedef logic [1:0] state_t;

   localparam state_t ST_RUN      = 2'd0;
   localparam state_t ST_MEM_WAIT = 2'd1;
   localparam state_t ST_FAULT    = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the datapath and the hazard controller: hazard sources in,
// per-register stall/flush controls plus status out.
interface pipe_hazard_ctrl_if #(
   parameter int WAIT_W = 5,
   parameter int PERF_W = 32
);
   import pipe_hazard_ctrl_pkg::*;

   logic [REG_IDX_W-1:0] id_rs1;
   logic [REG_IDX_W-1:0] id_rs2;
   logic                 id_use_rs1;
   logic                 id_use_rs2;
   logic [REG_IDX_W-1:0] ex_rd;
   logic                 ex_mem_read;
   logic                 ex_branch_taken;
   logic                 mem_access;
   logic                 dmem_ready;
   logic                 fault_clear;

   logic                 stall_pc;
   logic                 stall_if_id;
   logic                 stall_id_ex;
   logic                 stall_ex_mem;
   logic                 stall_mem_wb;
   logic                 flush_if_id;
   logic                 flush_id_ex;
   logic                 flush_ex_mem;
   logic                 flush_mem_wb;
   logic                 mem_fault;
   logic [WAIT_W-1:0]    wait_cnt;
   logic [PERF_W-1:0]    perf_stall_cnt;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             ex_branch_taken, mem_access, dmem_ready, fault_clear,
      input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
             flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
             mem_fault, wait_cnt, perf_stall_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             ex_branch_taken, mem_access, dmem_ready, fault_clear,
      output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
             flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
             mem_fault, wait_cnt, perf_stall_cnt
   );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Load-use comparator: does the ID instruction read the register a load in EX writes?
// Latency: purely combinational.
// Backpressure: none; the hit feeds the stall logic in the same cycle.
module hazard_cmp
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] rs1,
   input  logic [REG_IDX_W-1:0] rs2,
   input  logic                 use_rs1,
   input  logic                 use_rs2,
   input  logic [REG_IDX_W-1:0] rd,
   input  logic                 mem_read,
   output logic                 hit
);

   // Writes to x0 are discarded, so they can never create a dependency.
   assign hit = mem_read && (rd != REG_X0) &&
                ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for PC and the four pipeline registers, with memory-wait timeout.
// Latency: stall/flush combinational from state+inputs; state and counters registered.
// Backpressure: dmem_ready low on a memory access freezes PC..EX/MEM and bubbles MEM/WB.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int WAIT_W   = 5,
   parameter int PERF_W   = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   pipe_hazard_ctrl_if.slave hz
);

   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

   state_t              state;
   state_t              state_nxt;
   logic [WAIT_W-1:0]   wait_q;
   logic [WAIT_W-1:0]   wait_nxt;
   logic                fault_q;
   logic                fault_nxt;
   logic [PERF_W-1:0]   perf_q;
   logic                load_use_hit;
   logic                mem_wait;

   hazard_cmp u_hazard_cmp (
      .rs1      (hz.id_rs1),
      .rs2      (hz.id_rs2),
      .use_rs1  (hz.id_use_rs1),
      .use_rs2  (hz.id_use_rs2),
      .rd       (hz.ex_rd),
      .mem_read (hz.ex_mem_read),
      .hit      (load_use_hit)
   );

   assign mem_wait = hz.mem_access && !hz.dmem_ready;

   // A memory wait freezes EX and ID, so branch and load-use responses wait for release.
   always_comb begin
      hz.stall_pc     = 1'b0;
      hz.stall_if_id  = 1'b0;
      hz.stall_id_ex  = 1'b0;
      hz.stall_ex_mem = 1'b0;
      hz.stall_mem_wb = 1'b0;
      hz.flush_if_id  = 1'b0;
      hz.flush_id_ex  = 1'b0;
      hz.flush_ex_mem = 1'b0;
      hz.flush_mem_wb = 1'b0;
      if (state == ST_FAULT) begin
         hz.stall_pc     = 1'b1;
         hz.flush_if_id  = 1'b1;
         hz.flush_id_ex  = 1'b1;
         hz.flush_ex_mem = 1'b1;
         hz.flush_mem_wb = 1'b1;
      end else if (mem_wait) begin
         hz.stall_pc     = 1'b1;
         hz.stall_if_id  = 1'b1;
         hz.stall_id_ex  = 1'b1;
         hz.stall_ex_mem = 1'b1;
         hz.flush_mem_wb = 1'b1;
      end else if (hz.ex_branch_taken) begin
         hz.flush_if_id  = 1'b1;
         hz.flush_id_ex  = 1'b1;
      end else if (load_use_hit) begin
         hz.stall_pc     = 1'b1;
         hz.stall_if_id  = 1'b1;
         hz.flush_id_ex  = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_q;
      fault_nxt = fault_q;
      case (state)
         ST_RUN: begin
            if (mem_wait) begin
               state_nxt = ST_MEM_WAIT;
               wait_nxt  = WAIT_ONE;
            end
         end
         ST_MEM_WAIT: begin
            if (!mem_wait) begin
               state_nxt = ST_RUN;
               wait_nxt  = '0;
            end else if (wait_q < WAIT_MAX) begin
               wait_nxt  = wait_q + WAIT_ONE;
            end else begin
               state_nxt = ST_FAULT;
               fault_nxt = 1'b1;
            end
         end
         ST_FAULT: begin
            if (hz.fault_clear) begin
               state_nxt = ST_RUN;
               wait_nxt  = '0;
               fault_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = ST_RUN;
            wait_nxt  = '0;
            fault_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_RUN;
         wait_q  <= '0;
         fault_q <= 1'b0;
         perf_q  <= '0;
      end else begin
         state   <= state_nxt;
         wait_q  <= wait_nxt;
         fault_q <= fault_nxt;
         if (hz.stall_pc && (perf_q != '1))
            perf_q <= perf_q + PERF_W'(1);
      end
   end

   assign hz.mem_fault      = fault_q;
   assign hz.wait_cnt       = wait_q;
   assign hz.perf_stall_cnt = perf_q;

endmodule
